// File: rtl/td_lock_sequencer.sv
// td_lock_sequencer
// Field-qualified lock state machine that sits behind the TV-decoder
// stability detector. When the decoder has been stable for LOCK_FIELDS
// consecutive fields, it releases three staged active-low resets in the
// order 0, 1, 2. On lock loss it re-asserts all three resets together.
// It also reports how many HS lines the last complete field contained.
module td_lock_sequencer #(
    parameter int LOCK_FIELDS = 8,        // consecutive good fields needed to lock
    parameter int LOSS_FIELDS = 2,        // consecutive bad fields that drop lock
    parameter int VS_TIMEOUT  = 1620000,  // clocks without VS that drop lock
    parameter int RST_STEP    = 65536     // clocks between reset releases
) (
    input  logic       iCLK,
    input  logic       iRST_N,
    input  logic       iTD_VS,
    input  logic       iTD_HS,
    input  logic       iTD_Stable,
    output logic       oRST_0_N,
    output logic       oRST_1_N,
    output logic       oRST_2_N,
    output logic       oLocked,
    output logic       oLoss_Pulse,
    output logic [9:0] oLine_Cnt
);

    localparam int TO_W   = 21;
    localparam int REL_W  = 19;
    localparam int GOOD_W = $clog2(LOCK_FIELDS + 1);
    localparam int BAD_W  = $clog2(LOSS_FIELDS + 1);

    localparam logic [TO_W-1:0]   TO_MAX    = TO_W'(VS_TIMEOUT);
    localparam logic [GOOD_W-1:0] GOOD_MAX  = GOOD_W'(LOCK_FIELDS);
    localparam logic [BAD_W-1:0]  BAD_MAX   = BAD_W'(LOSS_FIELDS);
    localparam logic [REL_W-1:0]  REL_STEP0 = REL_W'(RST_STEP - 1);
    localparam logic [REL_W-1:0]  REL_STEP1 = REL_W'(2 * RST_STEP - 1);
    localparam logic [REL_W-1:0]  REL_STEP2 = REL_W'(3 * RST_STEP - 1);

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        RELEASE = 2'd1,
        LOCKED  = 2'd2
    } stateT;

    // ------------------------------------------------------------------
    // Input synchronisation and edge detection
    // ------------------------------------------------------------------
    // Bit 0 = VS, bit 1 = HS, bit 2 = Stable.
    logic [2:0] pinIn;
    logic [2:0] syncOut;
    logic [1:0] riseEvent;

    assign pinIn = {iTD_Stable, iTD_HS, iTD_VS};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : gSync
            logic syncMeta;
            logic syncStage;

            // Two-flop synchronizer; the upstream flag and syncs are not
            // related to iCLK.
            always_ff @(posedge iCLK or negedge iRST_N) begin
                if (!iRST_N) begin
                    syncMeta  <= 1'b0;
                    syncStage <= 1'b0;
                end else begin
                    syncMeta  <= pinIn[gi];
                    syncStage <= syncMeta;
                end
            end

            assign syncOut[gi] = syncStage;
        end

        for (gi = 0; gi < 2; gi++) begin : gEdge
            logic syncDly;

            // Third register so a rising edge on the synchronized level
            // becomes a single-cycle event.
            always_ff @(posedge iCLK or negedge iRST_N) begin
                if (!iRST_N) begin
                    syncDly <= 1'b0;
                end else begin
                    syncDly <= syncOut[gi];
                end
            end

            assign riseEvent[gi] = syncOut[gi] & ~syncDly;
        end
    endgenerate

    logic vsEvent;
    logic hsEvent;
    logic stableSync;

    assign vsEvent    = riseEvent[0];
    assign hsEvent    = riseEvent[1];
    assign stableSync = syncOut[2];

    // ------------------------------------------------------------------
    // VS watchdog
    // ------------------------------------------------------------------
    logic [TO_W-1:0] toCnt;
    logic            timeoutHit;

    // Clocks since the last VS event, parked at the timeout value.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            toCnt <= '0;
        end else if (vsEvent) begin
            toCnt <= '0;
        end else if (toCnt != TO_MAX) begin
            toCnt <= toCnt + TO_W'(1);
        end
    end

    assign timeoutHit = (toCnt == TO_MAX);

    // ------------------------------------------------------------------
    // Lines per field
    // ------------------------------------------------------------------
    logic [9:0] hsCnt;
    logic [9:0] lineCntReg;

    // Count HS events in the current field; a VS event publishes the count
    // and an HS arriving with that VS is the first line of the new field.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            hsCnt      <= '0;
            lineCntReg <= '0;
        end else if (vsEvent) begin
            lineCntReg <= hsCnt;
            hsCnt      <= hsEvent ? 10'd1 : 10'd0;
        end else if (hsEvent && (hsCnt != 10'd1023)) begin
            hsCnt <= hsCnt + 10'd1;
        end
    end

    // ------------------------------------------------------------------
    // Field qualification
    // ------------------------------------------------------------------
    stateT             stateReg;
    stateT             stateNext;
    logic [REL_W-1:0]  relCnt;
    logic [REL_W-1:0]  relCntNext;
    logic              lossFire;
    logic [GOOD_W-1:0] goodCnt;
    logic [GOOD_W-1:0] goodCntNext;
    logic [BAD_W-1:0]  badCnt;
    logic [BAD_W-1:0]  badCntNext;

    // Good/bad run lengths, updated per VS event; a watchdog expiry while
    // searching or any lock loss restarts qualification.
    always_comb begin
        goodCntNext = goodCnt;
        badCntNext  = badCnt;
        if (vsEvent) begin
            if (stableSync) begin
                if (goodCnt != GOOD_MAX) begin
                    goodCntNext = goodCnt + GOOD_W'(1);
                end
                badCntNext = '0;
            end else begin
                if (badCnt != BAD_MAX) begin
                    badCntNext = badCnt + BAD_W'(1);
                end
                goodCntNext = '0;
            end
        end
        if ((stateReg == SEARCH) && timeoutHit) begin
            goodCntNext = '0;
        end
        if (lossFire) begin
            goodCntNext = '0;
            badCntNext  = '0;
        end
    end

    // Qualification counter registers.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            goodCnt <= '0;
            badCnt  <= '0;
        end else begin
            goodCnt <= goodCntNext;
            badCnt  <= badCntNext;
        end
    end

    // ------------------------------------------------------------------
    // Lock FSM
    // ------------------------------------------------------------------
    logic rst0Reg, rst0Next;
    logic rst1Reg, rst1Next;
    logic rst2Reg, rst2Next;
    logic lockedReg, lockedNext;
    logic lossPulseReg, lossPulseNext;

    // State register, release counter and registered outputs.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            stateReg     <= SEARCH;
            relCnt       <= '0;
            rst0Reg      <= 1'b0;
            rst1Reg      <= 1'b0;
            rst2Reg      <= 1'b0;
            lockedReg    <= 1'b0;
            lossPulseReg <= 1'b0;
        end else begin
            stateReg     <= stateNext;
            relCnt       <= relCntNext;
            rst0Reg      <= rst0Next;
            rst1Reg      <= rst1Next;
            rst2Reg      <= rst2Next;
            lockedReg    <= lockedNext;
            lossPulseReg <= lossPulseNext;
        end
    end

    // Next state: loss outranks release progress once we have left SEARCH.
    always_comb begin
        stateNext  = stateReg;
        relCntNext = relCnt;
        lossFire   = (stateReg != SEARCH) && ((badCnt == BAD_MAX) || timeoutHit);
        case (stateReg)
            SEARCH: begin
                if (goodCnt == GOOD_MAX) begin
                    stateNext  = RELEASE;
                    relCntNext = '0;
                end
            end
            RELEASE: begin
                if (lossFire) begin
                    stateNext  = SEARCH;
                    relCntNext = '0;
                end else begin
                    relCntNext = relCnt + REL_W'(1);
                    if (relCnt == REL_STEP2) begin
                        stateNext = LOCKED;
                    end
                end
            end
            LOCKED: begin
                if (lossFire) begin
                    stateNext  = SEARCH;
                    relCntNext = '0;
                end
            end
            default: begin
                stateNext  = SEARCH;
                relCntNext = '0;
            end
        endcase
    end

    // Output decode: resets release one at a time, drop together on loss.
    always_comb begin
        rst0Next      = rst0Reg;
        rst1Next      = rst1Reg;
        rst2Next      = rst2Reg;
        lockedNext    = lockedReg;
        lossPulseNext = 1'b0;
        case (stateReg)
            SEARCH: begin
                rst0Next   = 1'b0;
                rst1Next   = 1'b0;
                rst2Next   = 1'b0;
                lockedNext = 1'b0;
            end
            RELEASE: begin
                if (lossFire) begin
                    rst0Next      = 1'b0;
                    rst1Next      = 1'b0;
                    rst2Next      = 1'b0;
                    lockedNext    = 1'b0;
                    lossPulseNext = 1'b1;
                end else if (relCnt == REL_STEP0) begin
                    rst0Next = 1'b1;
                end else if (relCnt == REL_STEP1) begin
                    rst1Next = 1'b1;
                end else if (relCnt == REL_STEP2) begin
                    rst2Next   = 1'b1;
                    lockedNext = 1'b1;
                end
            end
            LOCKED: begin
                if (lossFire) begin
                    rst0Next      = 1'b0;
                    rst1Next      = 1'b0;
                    rst2Next      = 1'b0;
                    lockedNext    = 1'b0;
                    lossPulseNext = 1'b1;
                end else begin
                    rst0Next   = 1'b1;
                    rst1Next   = 1'b1;
                    rst2Next   = 1'b1;
                    lockedNext = 1'b1;
                end
            end
            default: begin
                rst0Next   = 1'b0;
                rst1Next   = 1'b0;
                rst2Next   = 1'b0;
                lockedNext = 1'b0;
            end
        endcase
    end

    assign oRST_0_N    = rst0Reg;
    assign oRST_1_N    = rst1Reg;
    assign oRST_2_N    = rst2Reg;
    assign oLocked     = lockedReg;
    assign oLoss_Pulse = lossPulseReg;
    assign oLine_Cnt   = lineCntReg;

endmodule

// File: tb/tb_td_lock_sequencer.sv
// Testbench for td_lock_sequencer: directed lock/loss/line-count scenarios
// followed by randomized fields, all checked every cycle against a
// behavioural model built from run lengths and release age.
`timescale 1ns/1ps
module tb_td_lock_sequencer;

    localparam int LOCK = 4;
    localparam int LOSS = 2;
    localparam int TO   = 1000;
    localparam int STEP = 16;

    logic       iCLK = 1'b0;
    logic       iRST_N = 1'b0;
    logic       iTD_VS = 1'b0;
    logic       iTD_HS = 1'b0;
    logic       iTD_Stable = 1'b0;
    logic       oRST_0_N;
    logic       oRST_1_N;
    logic       oRST_2_N;
    logic       oLocked;
    logic       oLoss_Pulse;
    logic [9:0] oLine_Cnt;

    td_lock_sequencer #(
        .LOCK_FIELDS(LOCK),
        .LOSS_FIELDS(LOSS),
        .VS_TIMEOUT (TO),
        .RST_STEP   (STEP)
    ) dut (
        .iCLK       (iCLK),
        .iRST_N     (iRST_N),
        .iTD_VS     (iTD_VS),
        .iTD_HS     (iTD_HS),
        .iTD_Stable (iTD_Stable),
        .oRST_0_N   (oRST_0_N),
        .oRST_1_N   (oRST_1_N),
        .oRST_2_N   (oRST_2_N),
        .oLocked    (oLocked),
        .oLoss_Pulse(oLoss_Pulse),
        .oLine_Cnt  (oLine_Cnt)
    );

    always #5 iCLK = ~iCLK;

    int total = 0;
    int bad   = 0;
    int dutPulses = 0;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Pin history: index 1 = sampled one edge ago, 2 = two edges ago, ...
    int mdlN;
    bit hV1, hV2, hV3, hH1, hH2, hH3, hS1, hS2;
    int mode;          // 0 searching, 1 releasing, 2 locked
    int relStart;      // edge number at which release began
    int goodRun, badRun;
    int vsRef;         // edge number of the last VS event (0 after reset)
    int hsInField;
    int mLine;
    bit mRst0, mRst1, mRst2, mLocked, mPulse;

    function automatic void modelReset();
        mdlN = 0;
        {hV1, hV2, hV3, hH1, hH2, hH3, hS1, hS2} = '0;
        mode = 0; relStart = 0; goodRun = 0; badRun = 0;
        vsRef = 0; hsInField = 0; mLine = 0;
        {mRst0, mRst1, mRst2, mLocked, mPulse} = '0;
    endfunction

    // Advance the model across the coming rising edge, using the pins now driven.
    function automatic void modelStep();
        bit vsEv, hsEv, st, tmo, loss;
        int prevMode, age;
        mdlN++;
        vsEv = hV2 && !hV3;
        hsEv = hH2 && !hH3;
        st   = hS2;
        hV3 = hV2; hV2 = hV1; hV1 = iTD_VS;
        hH3 = hH2; hH2 = hH1; hH1 = iTD_HS;
        hS2 = hS1; hS1 = iTD_Stable;
        tmo = ((mdlN - 1 - vsRef) >= TO);
        prevMode = mode;
        loss = 1'b0;
        if (vsEv) begin
            mLine = (hsInField > 1023) ? 1023 : hsInField;
            hsInField = hsEv ? 1 : 0;
        end else if (hsEv) begin
            hsInField++;
        end
        if (prevMode == 0) begin
            if (goodRun >= LOCK) begin
                mode = 1;
                relStart = mdlN;
            end
        end else if (badRun >= LOSS || tmo) begin
            loss = 1'b1;
            mode = 0;
        end else if (prevMode == 1 && (mdlN - relStart) >= 3 * STEP) begin
            mode = 2;
        end
        if (vsEv) begin
            if (st) begin goodRun++; badRun = 0; end
            else    begin badRun++;  goodRun = 0; end
        end
        if (prevMode == 0 && tmo) goodRun = 0;
        if (loss) begin goodRun = 0; badRun = 0; end
        if (vsEv) vsRef = mdlN;
        age = mdlN - relStart;
        mRst0   = (mode != 0) && (age >= STEP);
        mRst1   = (mode != 0) && (age >= 2 * STEP);
        mRst2   = (mode == 2);
        mLocked = (mode == 2);
        mPulse  = loss;
    endfunction

    function automatic logic [14:0] dutVec();
        return {oRST_0_N, oRST_1_N, oRST_2_N, oLocked, oLoss_Pulse, oLine_Cnt};
    endfunction

    function automatic logic [14:0] mdlVec();
        return {mRst0, mRst1, mRst2, mLocked, mPulse, 10'(mLine)};
    endfunction

    // One clock: check outputs, then drive pins for the next rising edge.
    task automatic cyc(input bit vs, input bit hs, input bit st);
        @(negedge iCLK);
        checkVal("outs", 32'(dutVec()), 32'(mdlVec()));
        if (oLoss_Pulse === 1'b1) dutPulses++;
        iTD_VS = vs;
        iTD_HS = hs;
        iTD_Stable = st;
        if (iRST_N) modelStep();
    endtask

    // One field: VS high for 3 clocks, nHs evenly spaced HS pulses.
    task automatic field(input bit st, input int nHs, input int len, input bit coinc);
        int sp, cnt;
        bit hs;
        cnt = 0;
        sp = (nHs > 0) ? (len - 20) / nHs : 2;
        if (sp < 2) sp = 2;
        for (int c = 0; c < len; c++) begin
            hs = 1'b0;
            if (coinc && c == 0) hs = 1'b1;
            else if (c >= 10 && cnt < nHs && ((c - 10) % sp) == 0) begin
                hs = 1'b1;
                cnt++;
            end
            cyc(c < 3, hs, st);
        end
        $display("field stable=%0d hs=%0d len=%0d coinc=%0d -> locked=%0b rst=%0b%0b%0b line=%0d",
                 st, nHs + (coinc ? 1 : 0), len, coinc, oLocked, oRST_0_N, oRST_1_N, oRST_2_N, oLine_Cnt);
    endtask

    task automatic idle(input int len);
        for (int c = 0; c < len; c++) cyc(1'b0, (c % 20) == 5, 1'b1);
        $display("idle len=%0d -> locked=%0b line=%0d", len, oLocked, oLine_Cnt);
    endtask

    initial begin
        int p0;
        modelReset();
        iRST_N = 1'b0;
        repeat (4) cyc(1'b0, 1'b0, 1'b0);
        checkVal("reset_state", 32'(dutVec()), 32'd0);
        iRST_N = 1'b1;
        modelStep();

        // Basic lock: 4 good fields, then one more.
        repeat (4) field(1'b1, 10, 200, 1'b0);
        checkVal("lock_after4", 32'(oLocked), 32'd1);
        field(1'b1, 10, 200, 1'b0);
        checkVal("line_cnt10", 32'(oLine_Cnt), 32'd10);

        // A single bad field keeps lock.
        field(1'b0, 10, 200, 1'b0);
        field(1'b1, 10, 200, 1'b0);
        checkVal("single_bad_keeps", 32'(oLocked), 32'd1);

        // Two bad fields drop lock with exactly one pulse.
        p0 = dutPulses;
        field(1'b0, 10, 200, 1'b0);
        field(1'b0, 10, 200, 1'b0);
        checkVal("bad_loss_pulse", 32'(dutPulses - p0), 32'd1);
        checkVal("bad_loss_rst", 32'({oRST_0_N, oRST_1_N, oRST_2_N, oLocked}), 32'd0);

        // Interrupted qualification: 3 good, 1 bad, 3 good -> still searching.
        repeat (3) field(1'b1, 10, 200, 1'b0);
        field(1'b0, 10, 200, 1'b0);
        repeat (3) field(1'b1, 10, 200, 1'b0);
        checkVal("no_early_rst0", 32'(oRST_0_N), 32'd0);
        field(1'b1, 10, 200, 1'b0);
        checkVal("relock", 32'(oLocked), 32'd1);

        // VS stops: watchdog loss, one pulse.
        p0 = dutPulses;
        idle(1200);
        checkVal("timeout_pulse", 32'(dutPulses - p0), 32'd1);
        checkVal("timeout_unlock", 32'(oLocked), 32'd0);

        // Line counting: coincident HS belongs to the new field; saturation.
        field(1'b1, 10, 200, 1'b1);
        field(1'b1, 10, 200, 1'b0);
        checkVal("line_cnt_coinc", 32'(oLine_Cnt), 32'd11);
        field(1'b1, 1100, 2300, 1'b0);
        field(1'b1, 0, 10, 1'b0);
        checkVal("line_cnt_sat", 32'(oLine_Cnt), 32'd1023);

        // Reset in the middle of the release sequence.
        field(1'b0, 10, 200, 1'b0);
        field(1'b0, 10, 200, 1'b0);
        repeat (3) field(1'b1, 10, 200, 1'b0);
        field(1'b1, 0, 30, 1'b0);
        checkVal("mid_release_rst0", 32'(oRST_0_N), 32'd1);
        checkVal("mid_release_rst1", 32'(oRST_1_N), 32'd0);
        @(negedge iCLK);
        iRST_N = 1'b0;
        #1;
        checkVal("async_rst", 32'(dutVec()), 32'd0);
        modelReset();
        repeat (5) cyc(1'b0, 1'b0, 1'b0);
        iRST_N = 1'b1;
        modelStep();
        repeat (3) field(1'b1, 10, 200, 1'b0);
        checkVal("fresh_qual_needed", 32'(oLocked), 32'd0);
        field(1'b1, 10, 200, 1'b0);
        checkVal("fresh_relock", 32'(oLocked), 32'd1);

        // Randomized fields checked cycle by cycle against the model.
        for (int f = 0; f < 30; f++) begin
            if ($urandom_range(0, 9) == 0) idle(1100);
            field($urandom_range(0, 3) != 0, $urandom_range(5, 40),
                  $urandom_range(150, 260), $urandom_range(0, 1) == 1);
        end

        cyc(1'b0, 1'b0, 1'b1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/td_lock_sequencer.md
Name: td_lock_sequencer

Overview:
- Sits directly downstream of the TV-decoder stability detector. Consumes its stable flag together with the decoder VS/HS and runs a field-qualified lock state machine.
- Once lock is reached, releases three staged active-low resets to the ITU-656 decode, line-buffer and VGA/SDRAM stages.
- On lock loss, re-asserts all three resets at once.
- Also measures HS lines per field so board status can report PAL/NTSC line counts.

Parameters:
- LOCK_FIELDS, 8: consecutive qualified fields required to lock.
- LOSS_FIELDS, 2: consecutive unqualified fields that drop lock.
- VS_TIMEOUT, 1620000: clocks without a VS rising edge that drop lock (3 PAL fields at 27 MHz); 21-bit counter.
- RST_STEP, 65536: clocks between successive reset releases; release counter is 19 bits.

Ports:
- iCLK, input, 1: 27 MHz decoder clock (TD_CLK27); single clock domain.
- iRST_N, input, 1: asynchronous active-low reset.
- iTD_VS, input, 1: decoder vertical sync, rising edge marks field start.
- iTD_HS, input, 1: decoder horizontal sync, rising edge marks line start.
- iTD_Stable, input, 1: stable flag from upstream stability detector (HS-clocked, treated as asynchronous).
- oRST_0_N, output, 1: stage-0 reset (656 decoder), active low.
- oRST_1_N, output, 1: stage-1 reset (line buffer/YUV→RGB), active low.
- oRST_2_N, output, 1: stage-2 reset (SDRAM/VGA), active low.
- oLocked, output, 1: high only in LOCKED.
- oLoss_Pulse, output, 1: one-cycle pulse on any lock loss.
- oLine_Cnt, output, 10: HS rising edges counted in the last complete field.

Behaviour:
- Async reset:
  - All oRST_x_N = 0; oLocked = 0; oLoss_Pulse = 0; oLine_Cnt = 0.
  - State = SEARCH; all counters = 0; synchronizers = 0.
  - Reset mid-operation returns to this state immediately.
- Input synchronisation and edges:
  - iTD_VS, iTD_HS and iTD_Stable each pass through a 2-flop synchronizer.
  - Edge detect is taken on the synchronized value against a third register, so a pin rise produces an internal event 3 clocks later.
- Field qualification, on each VS event:
  - Synced Stable = 1: good_cnt += 1, saturating at LOCK_FIELDS; bad_cnt = 0.
  - Synced Stable = 0: bad_cnt += 1, saturating at LOSS_FIELDS; good_cnt = 0.
- VS timeout counter:
  - Cleared on a VS event, otherwise increments, saturating at VS_TIMEOUT.
  - "Timeout" means the counter equals VS_TIMEOUT.
- Line count:
  - hs_cnt increments on each HS event, saturating at 1023.
  - On a VS event, oLine_Cnt <= hs_cnt (before any same-cycle increment), and hs_cnt <= 1 if an HS event occurs in the same cycle, else 0.
- States and transitions:
  - SEARCH: all resets 0, oLocked 0.
    - good_cnt reaching LOCK_FIELDS (the registered value becomes LOCK_FIELDS) → RELEASE, with rel_cnt = 0.
    - Timeout clears good_cnt.
  - RELEASE: rel_cnt += 1.
    - rel_cnt == RST_STEP-1: oRST_0_N <= 1.
    - rel_cnt == 2*RST_STEP-1: oRST_1_N <= 1.
    - rel_cnt == 3*RST_STEP-1: oRST_2_N <= 1, oLocked <= 1, → LOCKED.
  - LOCKED: all resets 1; hold.
  - Loss, from RELEASE or LOCKED, on bad_cnt == LOSS_FIELDS or timeout:
    - Next edge: → SEARCH; all resets 0; oLocked 0; oLoss_Pulse 1 for exactly one cycle.
    - good_cnt, bad_cnt and rel_cnt cleared.
    - Loss has priority over release progress in the same cycle.
- A single bad field while in SEARCH restarts qualification (good_cnt = 0). No oLoss_Pulse is issued in SEARCH.
- Resets only release in the order 0, 1, 2, and are always re-asserted together.

Test Plan (LOCK_FIELDS=4, LOSS_FIELDS=2, VS_TIMEOUT=1000, RST_STEP=16; VS period 200 clk, 10 HS per field):
- Reset, then Stable=1 for 4 VS edges → state RELEASE 1 clk after the 4th VS event; oRST_0_N rises 16 clk later, oRST_1_N at 32, oRST_2_N and oLocked at 48.
- Stable=1 for 3 fields, 0 for 1 field, then 1 → lock only after 4 further good fields; all resets stay 0 meanwhile.
- In LOCKED, Stable=0 for 2 fields → on the 2nd VS event all resets 0 and oLocked 0 next clk; oLoss_Pulse high exactly 1 clk. A single bad field keeps lock.
- In LOCKED, stop VS → loss fires 1000 clk after the last VS event; oLoss_Pulse pulses once.
- 10 HS per field → oLine_Cnt = 10 after each VS event. HS coincident with VS → that HS counts toward the next field. 1100 HS in a field → oLine_Cnt = 1023.
- Assert iRST_N low mid-RELEASE (after oRST_0_N = 1) → all outputs 0 asynchronously; relock requires a fresh 4 good fields.
